chip8_mem_arbiter: RTL and testbench
====================================

CHIP8_MEM_ARBITER -- requirements
Module: chip8_mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 12, memory address width (4096 bytes).
REQ-002 Parameter: DATA_W, default 8, memory data width.
REQ-003 Parameter: MAX_BURST, default 16, maximum beats per locked ownership.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port clk_in, input, 1: sole clock, all state on rising edge.
REQ-006 Port rst_in_n, input, 1: asynchronous active-low reset.
REQ-007 Ports req_i[3], we_i[3], last_i[3], input, 1 each: per-requester request, write enable, final beat. Indices: 0 = rom loader, 1 = cpu, 2 = sprite draw engine.
REQ-008 Ports addr_i[3], input, ADDR_W each: per-requester byte address.
REQ-009 Ports wdata_i[3], input, DATA_W each: per-requester write data.
REQ-010 Port gnt_o, output, 3: one-hot beat accept; a beat transfers when req_i[n] && gnt_o[n].
REQ-011 Port rvalid_o, output, 3: read-data valid, per requester.
REQ-012 Port rdata_o, output, DATA_W: read data, shared by all requesters, qualified by rvalid_o.
REQ-013 Ports mem_en_o, mem_we_o, output, 1: memory access strobe and write enable.
REQ-014 Port mem_addr_o, output, ADDR_W: memory address.
REQ-015 Port mem_wdata_o, output, DATA_W: memory write data.
REQ-016 Port mem_rdata_i, input, DATA_W: memory read data, 1-cycle latency.
REQ-017 Port err_timeout_o, output, 1: one-cycle pulse on forced release.

Function
REQ-018 FSM states: IDLE (no owner), OWN_LDR, OWN_CPU, OWN_DRW.
REQ-019 In IDLE, the winner SHALL be chosen combinationally in the same cycle: loader first; otherwise cpu or draw per the round-robin pointer rr; otherwise the sole requester.
REQ-020 The winner's gnt_o bit SHALL assert in that same cycle, and its first beat SHALL transfer in that cycle.
REQ-021 If the first accepted beat carries last_i=1, the state SHALL stay IDLE; otherwise it SHALL move to OWN_<winner>.
REQ-022 In OWN_n, gnt_o SHALL equal req_i[n] at bit n only; other requesters SHALL be stalled, including the loader.
REQ-023 OWN_n SHALL return to IDLE on the accepted beat with last_i[n]=1.
REQ-024 An owner that deasserts req_i SHALL keep ownership: no beat transfers and no timeout advance.
REQ-025 On every accepted beat, mem_en_o=1, mem_we_o=we_i[n], mem_addr_o=addr_i[n], mem_wdata_o=wdata_i[n]; with no accepted beat, mem_en_o=0 and mem_we_o=0.
REQ-026 An accepted read beat at cycle t SHALL give rvalid_o[n]=1 and rdata_o=mem_rdata_i at t+1; writes SHALL produce no rvalid.
REQ-027 Sustained throughput SHALL be one beat per cycle with no bubble between back-to-back ownerships.
REQ-028 rr SHALL flip to the other of cpu/draw whenever a cpu or draw ownership ends.
REQ-029 rr SHALL be unchanged by loader ownership.
REQ-030 A 5-bit beat counter SHALL count accepted beats in the current ownership and clear on release.
REQ-031 If the counter reaches MAX_BURST with no last beat, the block SHALL force IDLE, pulse err_timeout_o for one cycle and flip rr as in a normal release.
REQ-032 The block SHALL NOT add read/write collision logic; exactly one beat can transfer per cycle.

Reset
REQ-033 On rst_in_n low, asynchronously: state=IDLE, rr=cpu, counter=0, rvalid_o=0, err_timeout_o=0, rdata_o=0.
REQ-034 During reset, gnt_o=0 and mem_en_o=0.
REQ-035 A reset asserted mid-ownership SHALL drop the owner; an in-flight rvalid SHALL be discarded.

Structure
REQ-036 Package chip8_pkg SHALL hold the requester index constants (REQ_LDR=0, REQ_CPU=1, REQ_DRW=2), the arbiter state enum, and the CHIP-8 ADDR_W/DATA_W constants.
REQ-037 The block SHALL be a single flat module with no sub-module; the round-robin pick is two gates.

Verification
REQ-038 Loader priority: all three req in IDLE, loader single beat read of 0x000 -> gnt_o=001, rvalid_o[0] next cycle, rdata_o=0xF0.
REQ-039 Round robin: cpu and draw request single beats every cycle -> grants alternate 010,100,010,...
REQ-040 Draw lock: draw 15-beat read burst at 0x300, cpu requesting throughout -> cpu stalled 15 cycles, cpu granted on cycle 16.
REQ-041 Timeout: cpu requests 20 beats with last never set -> forced release after beat 16, err_timeout_o one cycle, draw granted next.
REQ-042 Write-read: cpu writes 0x2A to 0x3FF, then reads it -> rvalid_o[1] with rdata_o=0x2A.
REQ-043 Reset mid-burst: rst_in_n low during draw ownership -> outputs at reset values; after release, cpu wins first.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 constants: memory geometry, requester indices and the
// memory-arbiter state encoding.
package chip8_pkg;

    localparam int CHIP8_ADDR_W = 12;
    localparam int CHIP8_DATA_W = 8;

    localparam logic [1:0] REQ_LDR = 2'd0;
    localparam logic [1:0] REQ_CPU = 2'd1;
    localparam logic [1:0] REQ_DRW = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN_LDR = 2'd1,
        ST_OWN_CPU = 2'd2,
        ST_OWN_DRW = 2'd3
    } arb_state_e;

endpackage

// File: rtl/chip8_mem_arbiter.sv
// Three-way memory arbiter for the CHIP-8 core: loader-priority pick in IDLE,
// cpu/draw round robin, locked bursts with a beat-count watchdog.
module chip8_mem_arbiter
    import chip8_pkg::*;
#(
    parameter int ADDR_W    = CHIP8_ADDR_W,
    parameter int DATA_W    = CHIP8_DATA_W,
    parameter int MAX_BURST = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in_n,
    input  logic [2:0]             req_i,
    input  logic [2:0]             we_i,
    input  logic [2:0]             last_i,
    input  logic [2:0][ADDR_W-1:0] addr_i,
    input  logic [2:0][DATA_W-1:0] wdata_i,
    output logic [2:0]             gnt_o,
    output logic [2:0]             rvalid_o,
    output logic [DATA_W-1:0]      rdata_o,
    output logic                   mem_en_o,
    output logic                   mem_we_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [DATA_W-1:0]      mem_wdata_o,
    input  logic [DATA_W-1:0]      mem_rdata_i,
    output logic                   err_timeout_o,
    output arb_state_e             dbg_state_o
);

    // Handshake: a beat transfers in any cycle where req_i[n] && gnt_o[n];
    // gnt_o is combinational on req_i, so a requester holds its beat until granted.
    arb_state_e state_q, state_d;
    logic       rr_q, rr_d;          // 0: cpu preferred, 1: draw preferred
    logic [4:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0] sel;
    logic [1:0] sel_idx;
    logic       accept, burst_full, timeout, release_beat;

    always_comb begin
        sel = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_i[REQ_LDR]) begin
                    sel[REQ_LDR] = 1'b1;
                end else begin
                    sel[REQ_CPU] = req_i[REQ_CPU] & (~req_i[REQ_DRW] | ~rr_q);
                    sel[REQ_DRW] = req_i[REQ_DRW] & (~req_i[REQ_CPU] |  rr_q);
                end
            end
            ST_OWN_LDR: sel[REQ_LDR] = req_i[REQ_LDR];
            ST_OWN_CPU: sel[REQ_CPU] = req_i[REQ_CPU];
            ST_OWN_DRW: sel[REQ_DRW] = req_i[REQ_DRW];
            default:    sel = '0;
        endcase
    end

    assign sel_idx      = sel[REQ_DRW] ? REQ_DRW : (sel[REQ_CPU] ? REQ_CPU : REQ_LDR);
    assign accept       = |sel;
    assign cnt_inc      = cnt_q + 5'd1;
    assign burst_full   = (int'(cnt_inc) == MAX_BURST);
    // A burst that fills without a last beat is cut short by the watchdog.
    assign timeout      = accept & ~last_i[sel_idx] & burst_full;
    assign release_beat = accept & (last_i[sel_idx] | burst_full);

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q       <= ST_IDLE;
            rr_q          <= 1'b0;
            cnt_q         <= '0;
            rvalid_o      <= '0;
            err_timeout_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            cnt_q         <= cnt_d;
            rvalid_o      <= (accept & ~we_i[sel_idx]) ? sel : 3'b000;
            err_timeout_o <= timeout;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        if (accept) begin
            if (release_beat) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                if (sel_idx != REQ_LDR) begin
                    rr_d = (sel_idx == REQ_CPU);
                end
            end else begin
                cnt_d = cnt_inc;
                case (sel_idx)
                    REQ_CPU: state_d = ST_OWN_CPU;
                    REQ_DRW: state_d = ST_OWN_DRW;
                    default: state_d = ST_OWN_LDR;
                endcase
            end
        end
    end

    // Outputs are forced quiet while reset is held, even with requests pending.
    always_comb begin
        gnt_o       = rst_in_n ? sel : 3'b000;
        mem_en_o    = rst_in_n & accept;
        mem_we_o    = rst_in_n & accept & we_i[sel_idx];
        mem_addr_o  = addr_i[sel_idx];
        mem_wdata_o = wdata_i[sel_idx];
        rdata_o     = (|rvalid_o) ? mem_rdata_i : '0;
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Bench for chip8_mem_arbiter: directed scenarios then randomized traffic,
// every cycle compared against a transaction-level arbitration model.
module tb_chip8_mem_arbiter;
    import chip8_pkg::*;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int MB = 16;

    logic                clk_in = 1'b0;
    logic                rst_in_n;
    logic [2:0]          req_i, we_i, last_i;
    logic [2:0][AW-1:0]  addr_i;
    logic [2:0][DW-1:0]  wdata_i;
    logic [2:0]          gnt_o, rvalid_o;
    logic [DW-1:0]       rdata_o, mem_wdata_o, mem_rdata_i;
    logic                mem_en_o, mem_we_o, err_timeout_o;
    logic [AW-1:0]       mem_addr_o;
    arb_state_e          dbg_state_o;

    int n_tests = 0;
    int n_fail  = 0;

    // memory behind the arbiter: unwritten locations return a fixed pattern
    logic [DW-1:0] mem [4096];
    bit            written [4096];
    logic [DW-1:0] shadow [4096];

    int            m_owner = -1;
    int            m_rr    = 1;
    int            m_beats = 0;
    logic [2:0]    exp_rvalid = 3'b000;
    logic [DW-1:0] exp_rdata  = '0;
    logic          exp_tmo    = 1'b0;

    logic [2:0]    s_gnt, s_rvalid;
    logic [DW-1:0] s_rdata;
    logic          s_tmo;

    chip8_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk_in(clk_in), .rst_in_n(rst_in_n),
        .req_i(req_i), .we_i(we_i), .last_i(last_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .err_timeout_o(err_timeout_o),
        .dbg_state_o(dbg_state_o)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [DW-1:0] init_val(input int a);
        logic [DW-1:0] font [5];
        font = '{8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0};
        if (a < 5) return font[a];
        return 8'(a * 37 + 11);
    endfunction

    always @(posedge clk_in) begin
        if (mem_en_o) begin
            if (mem_we_o) begin
                mem[mem_addr_o]     <= mem_wdata_o;
                written[mem_addr_o] <= 1'b1;
            end
            mem_rdata_i <= written[mem_addr_o] ? mem[mem_addr_o] : init_val(int'(mem_addr_o));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner    = -1;
        m_rr       = 1;
        m_beats    = 0;
        exp_rvalid = 3'b000;
        exp_tmo    = 1'b0;
    endtask

    // Called at posedge+1 with inputs applied; checks this cycle, advances the model.
    task automatic step();
        int g;
        #2;
        s_gnt = gnt_o; s_rvalid = rvalid_o; s_rdata = rdata_o; s_tmo = err_timeout_o;
        if (m_owner >= 0)                g = req_i[m_owner] ? m_owner : -1;
        else if (req_i[0])               g = 0;
        else if (req_i[1] && req_i[2])   g = m_rr;
        else if (req_i[1])               g = 1;
        else if (req_i[2])               g = 2;
        else                             g = -1;
        chk("gnt", gnt_o, (g >= 0) ? 3'(1 << g) : 3'b000);
        chk("mem_en", mem_en_o, g >= 0);
        chk("mem_we", mem_we_o, (g >= 0) ? we_i[g] : 1'b0);
        if (g >= 0) begin
            chk("mem_addr", mem_addr_o, addr_i[g]);
            if (we_i[g]) chk("mem_wdata", mem_wdata_o, wdata_i[g]);
        end
        chk("rvalid", rvalid_o, exp_rvalid);
        if (exp_rvalid != 3'b000) chk("rdata", rdata_o, exp_rdata);
        chk("err_timeout", err_timeout_o, exp_tmo);

        exp_rvalid = 3'b000;
        exp_tmo    = 1'b0;
        if (g >= 0) begin
            m_beats++;
            if (!we_i[g]) begin
                exp_rvalid = 3'(1 << g);
                exp_rdata  = shadow[addr_i[g]];
            end else begin
                shadow[addr_i[g]] = wdata_i[g];
            end
            if (last_i[g] || m_beats == MB) begin
                exp_tmo = !last_i[g];
                if (g != 0) m_rr = (g == 1) ? 2 : 1;
                m_owner = -1;
                m_beats = 0;
            end else begin
                m_owner = g;
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic cyc(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l);
        req_i = r; we_i = w; last_i = l;
        step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"}, gnt_o, 3'b000);
        chk({tag, "_mem_en"}, mem_en_o, 1'b0);
        chk({tag, "_rvalid"}, rvalid_o, 3'b000);
        chk({tag, "_rdata"}, rdata_o, '0);
        chk({tag, "_tmo"}, err_timeout_o, 1'b0);
    endtask

    initial begin
        int lastp;
        for (int i = 0; i < 4096; i++) shadow[i] = init_val(i);
        rst_in_n = 1'b0;
        req_i = '0; we_i = '0; last_i = '0; addr_i = '0; wdata_i = '0;
        repeat (2) @(posedge clk_in);
        #1;

        // reset with all requesters active
        req_i = 3'b111;
        #2;
        chk_reset_outputs("rst");
        req_i = 3'b000;
        rst_in_n = 1'b1;
        @(posedge clk_in);
        #1;

        // loader priority, font byte at 0x000
        addr_i[0] = 12'h000; addr_i[1] = 12'h200; addr_i[2] = 12'h300;
        cyc(3'b111, 3'b000, 3'b111);
        chk("ldr_gnt", s_gnt, 3'b001);
        cyc(3'b000, 3'b000, 3'b000);
        chk("ldr_rvalid", s_rvalid, 3'b001);
        chk("ldr_rdata", s_rdata, 8'hF0);

        // round robin between cpu and draw
        for (int i = 0; i < 5; i++) begin
            cyc(3'b110, 3'b000, 3'b110);
            chk("rr_gnt", s_gnt, (i % 2) ? 3'b100 : 3'b010);
        end

        // draw locks a 15-beat burst while cpu waits
        addr_i[1] = 12'h123;
        for (int i = 0; i < 16; i++) begin
            addr_i[2] = 12'h300 + 12'(i);
            cyc((i < 15) ? 3'b110 : 3'b010, 3'b000, {i == 14, 1'b1, 1'b0});
            chk((i < 15) ? "lock_drw" : "lock_cpu", s_gnt, (i < 15) ? 3'b100 : 3'b010);
        end

        // cpu burst without last: watchdog releases after beat 16
        addr_i[1] = 12'h050;
        for (int i = 0; i < 16; i++) begin
            cyc({i > 0, 1'b1, 1'b0}, 3'b000, 3'b100);
            chk("to_cpu", s_gnt, 3'b010);
            chk("to_quiet", s_tmo, 1'b0);
        end
        cyc(3'b110, 3'b000, 3'b100);
        chk("to_drw", s_gnt, 3'b100);
        chk("to_pulse", s_tmo, 1'b1);
        for (int j = 0; j < 4; j++) begin
            cyc(3'b010, 3'b000, {1'b0, j == 3, 1'b0});
            chk("to_cpu_resume", s_gnt, 3'b010);
            if (j == 0) chk("to_single", s_tmo, 1'b0);
        end

        // cpu write then read back
        addr_i[1] = 12'h3FF; wdata_i[1] = 8'h2A;
        cyc(3'b010, 3'b010, 3'b010);
        cyc(3'b010, 3'b000, 3'b010);
        chk("wr_norvalid", s_rvalid, 3'b000);
        cyc(3'b000, 3'b000, 3'b000);
        chk("wr_rvalid", s_rvalid, 3'b010);
        chk("wr_rdata", s_rdata, 8'h2A);

        // reset during draw ownership with a read in flight
        addr_i[2] = 12'h310;
        cyc(3'b100, 3'b000, 3'b000);
        cyc(3'b100, 3'b000, 3'b000);
        rst_in_n = 1'b0;
        req_i = 3'b110;
        #2;
        chk_reset_outputs("rst_mid");
        model_reset();
        req_i = 3'b000;
        rst_in_n = 1'b1;
        @(posedge clk_in);
        #1;
        cyc(3'b110, 3'b000, 3'b110);
        chk("rst_cpu_first", s_gnt, 3'b010);
        chk("rst_discard", s_rvalid, 3'b000);

        // randomized traffic: frequent lasts, then rare lasts to reach the watchdog
        for (int i = 0; i < 800; i++) begin
            lastp = (i < 400) ? 30 : 3;
            for (int n = 0; n < 3; n++) begin
                addr_i[n]  = 12'h300 + 12'($urandom_range(15));
                wdata_i[n] = 8'($urandom);
                last_i[n]  = ($urandom_range(99) < lastp);
            end
            req_i = 3'($urandom);
            we_i  = 3'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
